dot_accumulator: RTL and testbench

DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

---
 rtl/dot_accumulator.sv | 122 ++++++++++++
 tb/tb_dot_accumulator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dot_accumulator.sv
// Sums VEC_LEN unsigned products from the multiplier into one matrix element and
// queues finished elements in a 2-entry result FIFO; the multiplier is never stalled.
module dot_accumulator #(
    parameter int PROD_W  = 64,
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 72
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       prod_valid,
    input  logic [PROD_W-1:0]          prod,
    input  logic                       clear,
    input  logic                       res_ready,
    output logic                       res_valid,
    output logic [ACC_W-1:0]           res_data,
    output logic                       busy,
    output logic [$clog2(VEC_LEN):0]   elem_cnt,
    output logic                       overflow_err
);

    localparam int CNT_W = $clog2(VEC_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    if (VEC_LEN < 1 || ACC_W < PROD_W + $clog2(VEC_LEN)) begin : g_param_check
        $error("dot_accumulator: need VEC_LEN >= 1 and ACC_W >= PROD_W + clog2(VEC_LEN)");
    end

    function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] a,
                                                  input logic [PROD_W-1:0] b);
        return a + ACC_W'(b);
    endfunction

    logic [ACC_W-1:0] acc_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic [ACC_W-1:0] sum_p0;
    logic             vld_p0;

    logic [ACC_W-1:0] head_p1;
    logic [ACC_W-1:0] tail_p1;
    logic [1:0]       count_p1;
    logic             ovf_p1;

    logic             pop;
    logic             push;
    logic             drop;

    always_comb begin
        sum_p0 = wrap_add(acc_p0, prod);
        vld_p0 = prod_valid && !clear && (cnt_p0 == LAST_IDX);
        pop    = (count_p1 != 2'd0) && res_ready;
        push   = vld_p0 && ((count_p1 != 2'd2) || pop);
        drop   = vld_p0 && (count_p1 == 2'd2) && !pop;
    end

    // Stage p0: running partial sum; the final product bypasses acc straight into the FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
        end else if (clear) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
        end else if (prod_valid) begin
            if (cnt_p0 == LAST_IDX) begin
                acc_p0 <= '0;
                cnt_p0 <= '0;
            end else begin
                acc_p0 <= sum_p0;
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
        end
    end

    // Stage p1: two-entry shift FIFO, head register drives res_data directly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_p1  <= '0;
            tail_p1  <= '0;
            count_p1 <= 2'd0;
            ovf_p1   <= 1'b0;
        end else begin
            if (drop) begin
                ovf_p1 <= 1'b1;
            end
            case (count_p1)
                2'd0: begin
                    if (push) begin
                        head_p1  <= sum_p0;
                        count_p1 <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_p1 <= sum_p0;
                    end else if (push) begin
                        tail_p1  <= sum_p0;
                        count_p1 <= 2'd2;
                    end else if (pop) begin
                        count_p1 <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_p1 <= tail_p1;
                        if (push) begin
                            tail_p1 <= sum_p0;
                        end else begin
                            count_p1 <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign res_valid    = (count_p1 != 2'd0);
    assign res_data     = head_p1;
    assign busy         = (cnt_p0 != '0);
    assign elem_cnt     = cnt_p0;
    assign overflow_err = ovf_p1;

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator: default configuration plus a VEC_LEN=1 instance.
module tb_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prod_valid;
    logic [63:0] prod;
    logic        clear;
    logic        res_ready;

    logic        res_valid;
    logic [71:0] res_data;
    logic        busy;
    logic [2:0]  elem_cnt;
    logic        overflow_err;

    logic        u1_res_valid;
    logic [63:0] u1_res_data;
    logic        u1_busy;
    logic [0:0]  u1_elem_cnt;
    logic        u1_overflow_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_accumulator dut (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod(prod),
        .clear(clear), .res_ready(res_ready), .res_valid(res_valid),
        .res_data(res_data), .busy(busy), .elem_cnt(elem_cnt),
        .overflow_err(overflow_err)
    );

    dot_accumulator #(.PROD_W(64), .VEC_LEN(1), .ACC_W(64)) dut_v1 (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod(prod),
        .clear(clear), .res_ready(res_ready), .res_valid(u1_res_valid),
        .res_data(u1_res_data), .busy(u1_busy), .elem_cnt(u1_elem_cnt),
        .overflow_err(u1_overflow_err)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [63:0] v);
        prod_valid = 1'b1;
        prod       = v;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic vec(input logic [63:0] a, b, c, d);
        put(a); put(b); put(c); put(d);
    endtask

    task automatic pop_one();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; prod_valid = 1'b0; prod = '0; clear = 1'b0; res_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 72'(res_valid), 72'd0);
        chk("rst_data", res_data, 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_cnt", 72'(elem_cnt), 72'd0);
        chk("rst_ovf", 72'(overflow_err), 72'd0);
        rst_n = 1'b1;

        // basic sum 1+2+3+4
        put(64'd1);
        chk("v1_valid", 72'(u1_res_valid), 72'd1);
        chk("v1_data", 72'(u1_res_data), 72'd1);
        chk("v1_cnt", 72'(u1_elem_cnt), 72'd0);
        put(64'd2); put(64'd3);
        chk("basic_cnt3", 72'(elem_cnt), 72'd3);
        chk("basic_busy3", 72'(busy), 72'd1);
        chk("basic_novalid", 72'(res_valid), 72'd0);
        put(64'd4);
        chk("basic_valid", 72'(res_valid), 72'd1);
        chk("basic_data", res_data, 72'd10);
        chk("basic_busy0", 72'(busy), 72'd0);
        chk("basic_cnt0", 72'(elem_cnt), 72'd0);
        pop_one();
        chk("basic_popped", 72'(res_valid), 72'd0);

        // maximum products
        vec(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("max_data", res_data, 72'h3_FFFF_FFFF_FFFF_FFFC);
        pop_one();

        // clear mid-vector discards the partial sum and the coincident product
        put(64'd5); put(64'd6);
        clear = 1'b1; prod_valid = 1'b1; prod = 64'd9;
        tick();
        clear = 1'b0; prod_valid = 1'b0;
        chk("clr_cnt", 72'(elem_cnt), 72'd0);
        chk("clr_novalid", 72'(res_valid), 72'd0);
        vec(64'd1, 64'd1, 64'd1, 64'd1);
        chk("clr_data", res_data, 72'd4);
        pop_one();
        chk("clr_single", 72'(res_valid), 72'd0);

        // backpressure then overflow
        vec(64'd1, 64'd2, 64'd3, 64'd4);
        vec(64'd2, 64'd4, 64'd6, 64'd8);
        chk("bp_valid", 72'(res_valid), 72'd1);
        chk("bp_data", res_data, 72'd10);
        chk("bp_ovf0", 72'(overflow_err), 72'd0);
        tick();
        chk("bp_stable", res_data, 72'd10);
        vec(64'd3, 64'd6, 64'd9, 64'd12);
        chk("ovf_set", 72'(overflow_err), 72'd1);
        chk("ovf_head", res_data, 72'd10);
        chk("ovf_cnt", 72'(elem_cnt), 72'd0);
        res_ready = 1'b1;
        tick();
        chk("ovf_second", res_data, 72'd20);
        chk("ovf_second_v", 72'(res_valid), 72'd1);
        tick();
        chk("ovf_empty", 72'(res_valid), 72'd0);
        res_ready = 1'b0;
        chk("ovf_sticky", 72'(overflow_err), 72'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ovf_rst", 72'(overflow_err), 72'd0);

        // full FIFO with simultaneous pop and push
        vec(64'd1, 64'd2, 64'd3, 64'd4);
        vec(64'd2, 64'd4, 64'd6, 64'd8);
        put(64'd3); put(64'd6); put(64'd9);
        res_ready = 1'b1;
        put(64'd12);
        chk("pp_ovf", 72'(overflow_err), 72'd0);
        chk("pp_first", res_data, 72'd20);
        tick();
        chk("pp_second", res_data, 72'd30);
        chk("pp_second_v", 72'(res_valid), 72'd1);
        tick();
        chk("pp_empty", 72'(res_valid), 72'd0);
        res_ready = 1'b0;

        // reset mid-operation
        vec(64'd1, 64'd2, 64'd3, 64'd4);
        put(64'd1); put(64'd1);
        chk("mr_cnt2", 72'(elem_cnt), 72'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_valid", 72'(res_valid), 72'd0);
        chk("mr_cnt", 72'(elem_cnt), 72'd0);
        chk("mr_data", res_data, 72'd0);
        vec(64'd1, 64'd1, 64'd1, 64'd1);
        chk("mr_result_v", 72'(res_valid), 72'd1);
        chk("mr_result", res_data, 72'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
